// File: rtl/timer_pkg.sv
// Shared definitions for the rv_timer_ctrl register block and its timer_core datapath.
package timer_pkg;

  // Register byte offsets (word aligned, 9-bit bus address space)
  localparam logic [8:0] OFF_CTRL          = 9'h000;
  localparam logic [8:0] OFF_CFG           = 9'h004;
  localparam logic [8:0] OFF_MTIME_LO      = 9'h008;
  localparam logic [8:0] OFF_MTIME_HI      = 9'h00C;
  localparam logic [8:0] OFF_MTIMECMP_BASE = 9'h010;  // lo at +8i, hi at +8i+4
  localparam logic [8:0] OFF_INTR_STATE    = 9'h100;
  localparam logic [8:0] OFF_INTR_ENABLE   = 9'h104;
  localparam logic [8:0] OFF_INTR_TEST     = 9'h108;

  // CTRL / CFG field positions
  localparam int CTRL_ACTIVE_BIT = 0;
  localparam int PRESC_W         = 12;
  localparam int STEP_W          = 8;
  localparam int CFG_PRESC_LSB   = 0;
  localparam int CFG_STEP_LSB    = 16;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [STEP_W-1:0]  step;
    logic [PRESC_W-1:0] prescaler;
  } cfg_t;

  // Place the CFG fields at their bus bit positions.
  function automatic logic [31:0] cfg_to_word(cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CFG_PRESC_LSB +: PRESC_W] = c.prescaler;
    w[CFG_STEP_LSB  +: STEP_W]  = c.step;
    return w;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Timer datapath: prescaler tick generation, mtime increment and per-channel compare.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 active_i,
  input  logic [PRESC_W-1:0]   prescaler_i,
  input  logic [STEP_W-1:0]    step_i,
  input  logic [63:0]          mtime_i,
  input  logic [N-1:0][63:0]   mtimecmp_i,
  output logic                 tick_o,
  output logic [63:0]          mtime_d_o,
  output logic [N-1:0]         intr_o
);

  logic [PRESC_W-1:0] count_q, count_d;

  // Comparing with >= lets a lowered prescaler take effect without resetting the count.
  assign tick_o    = active_i && (count_q >= prescaler_i);
  assign mtime_d_o = mtime_i + 64'(step_i);

  // Next prescaler count: held at zero while inactive, restarts after each tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q + PRESC_W'(1);
    if (!active_i || tick_o) begin
      count_d = '0;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Unsigned 64-bit compare per channel, gated by the active bit.
  always_comb begin
    intr_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      intr_o[i] = active_i && (mtime_i >= mtimecmp_i[i]);
    end
  end

endmodule

// File: rtl/rv_timer_ctrl.sv
// Register front end for timer_core: bus decode, CTRL/CFG/mtime/mtimecmp/interrupt registers
// and the registered single-cycle response path.
module rv_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [8:0]    addr_i,
  input  logic [31:0]   wdata_i,
  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          err_o,
  output logic [N-1:0]  intr_o
);

  localparam logic [9:0] CMP_END = 10'(OFF_MTIMECMP_BASE) + 10'(8 * N);

  // Register state
  logic               ctrl_active_q, ctrl_active_d;
  cfg_t               cfg_q, cfg_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [N-1:0][63:0] mtimecmp_q, mtimecmp_d;
  logic [N-1:0]       intr_state_q, intr_state_d;
  logic [N-1:0]       intr_enable_q, intr_enable_d;
  logic [N-1:0]       intr_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  // Core interface
  logic               core_tick;
  logic [63:0]        core_mtime_d;
  logic [N-1:0]       core_intr;

  // Address decode (byte lanes addr_i[1:0] are ignored)
  logic [6:0]   waddr;
  logic [8:0]   off;
  logic [6:0]   cmp_wrel;
  logic         in_cmp, cmp_hi;
  logic [N-1:0] cmp_sel;
  logic         mapped, wr, rd;
  logic         unused_addr;

  assign waddr       = addr_i[8:2];
  assign off         = {waddr, 2'b00};
  assign unused_addr = ^addr_i[1:0];
  assign cmp_wrel    = waddr - OFF_MTIMECMP_BASE[8:2];
  assign cmp_hi      = cmp_wrel[0];
  assign in_cmp      = (off >= OFF_MTIMECMP_BASE) && ({1'b0, off} < CMP_END);
  assign wr          = req_i && we_i;
  assign rd          = req_i && !we_i;

  // One-hot select of the addressed mtimecmp channel.
  always_comb begin
    cmp_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      cmp_sel[i] = in_cmp && (cmp_wrel[6:1] == 6'(i));
    end
  end

  assign mapped = (off == OFF_CTRL) || (off == OFF_CFG) || (off == OFF_MTIME_LO) ||
                  (off == OFF_MTIME_HI) || (off == OFF_INTR_STATE) ||
                  (off == OFF_INTR_ENABLE) || (off == OFF_INTR_TEST) || (|cmp_sel);

  timer_core #(.N(N)) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .active_i    (ctrl_active_q),
    .prescaler_i (cfg_q.prescaler),
    .step_i      (cfg_q.step),
    .mtime_i     (mtime_q),
    .mtimecmp_i  (mtimecmp_q),
    .tick_o      (core_tick),
    .mtime_d_o   (core_mtime_d),
    .intr_o      (core_intr)
  );

  // Register next-state: bus writes, mtime advance and sticky interrupt state.
  always_comb begin
    ctrl_active_d = ctrl_active_q;
    cfg_d         = cfg_q;
    mtime_d       = mtime_q;
    mtimecmp_d    = mtimecmp_q;
    intr_enable_d = intr_enable_q;
    intr_state_d  = intr_state_q;

    if (wr && off == OFF_CTRL) ctrl_active_d = wdata_i[CTRL_ACTIVE_BIT];
    if (wr && off == OFF_CFG) begin
      cfg_d.prescaler = wdata_i[CFG_PRESC_LSB +: PRESC_W];
      cfg_d.step      = wdata_i[CFG_STEP_LSB  +: STEP_W];
    end

    // A bus write to either half wins over a coincident tick; the other half keeps its old value.
    if (core_tick)                mtime_d = core_mtime_d;
    if (wr && off == OFF_MTIME_LO) mtime_d = {mtime_q[63:32], wdata_i};
    if (wr && off == OFF_MTIME_HI) mtime_d = {wdata_i, mtime_q[31:0]};

    for (int i = 0; i < int'(N); i++) begin
      if (wr && cmp_sel[i]) begin
        if (cmp_hi) mtimecmp_d[i][63:32] = wdata_i;
        else        mtimecmp_d[i][31:0]  = wdata_i;
      end
    end

    if (wr && off == OFF_INTR_ENABLE) intr_enable_d = wdata_i[N-1:0];

    // W1C applied first so a same-cycle hit or test write keeps the bit set.
    if (wr && off == OFF_INTR_STATE) intr_state_d = intr_state_d & ~wdata_i[N-1:0];
    intr_state_d = intr_state_d | core_intr;
    if (wr && off == OFF_INTR_TEST)  intr_state_d = intr_state_d | wdata_i[N-1:0];
  end

  // Response data: read mux, zero on writes and unmapped addresses.
  always_comb begin
    rdata_d = '0;
    err_d   = req_i && !mapped;
    if (rd) begin
      case (off)
        OFF_CTRL:        rdata_d[CTRL_ACTIVE_BIT] = ctrl_active_q;
        OFF_CFG:         rdata_d = cfg_to_word(cfg_q);
        OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
        OFF_MTIME_HI:    rdata_d = mtime_q[63:32];
        OFF_INTR_STATE:  rdata_d = 32'(intr_state_q);
        OFF_INTR_ENABLE: rdata_d = 32'(intr_enable_q);
        default: begin
          for (int i = 0; i < int'(N); i++) begin
            if (cmp_sel[i]) rdata_d = cmp_hi ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
          end
        end
      endcase
    end
  end

  // Architectural registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_active_q <= 1'b0;
      cfg_q         <= '0;
      mtime_q       <= '0;
      // NOTE: the mtimecmp array is plain flops, so it is reset like any other register.
      mtimecmp_q    <= {N{MTIMECMP_RST}};
      intr_state_q  <= '0;
      intr_enable_q <= '0;
      intr_q        <= '0;
    end else begin
      ctrl_active_q <= ctrl_active_d;
      cfg_q         <= cfg_d;
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      intr_state_q  <= intr_state_d;
      intr_enable_q <= intr_enable_d;
      intr_q        <= intr_state_q & intr_enable_q;
    end
  end

  // Bus response, one cycle after every request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign intr_o   = intr_q;

endmodule

// File: tb/tb_rv_timer_ctrl.sv
// Self-checking bench for rv_timer_ctrl with a cycle-level behavioural model of the register map.
module tb_rv_timer_ctrl;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [8:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;
  logic [N-1:0]  intr;

  rv_timer_ctrl #(.N(N)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .intr_o   (intr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  bit           m_active;
  int           m_presc;
  int           m_step;
  int           m_cnt;        // cycles elapsed since the last tick while active
  logic [63:0]  m_mtime;
  logic [63:0]  m_cmp [N];
  logic [N-1:0] m_state, m_enable, m_intr_line;

  logic          got_rvalid, exp_rvalid;
  logic [31:0]   got_rdata,  exp_rdata;
  logic          got_err,    exp_err;
  logic [N-1:0]  got_intr,   exp_intr;

  function automatic bit is_mapped(logic [8:0] off);
    if (off inside {9'h000, 9'h004, 9'h008, 9'h00C, 9'h100, 9'h104, 9'h108}) return 1'b1;
    return (int'(off) >= 16) && (int'(off) < 16 + 8 * N);
  endfunction

  function automatic logic [31:0] read_val(logic [8:0] off);
    int idx;
    case (off)
      9'h000: return {31'd0, m_active};
      9'h004: return {8'd0, 8'(m_step), 4'd0, 12'(m_presc)};
      9'h008: return m_mtime[31:0];
      9'h00C: return m_mtime[63:32];
      9'h100: return 32'(m_state);
      9'h104: return 32'(m_enable);
      default: begin
        if (!is_mapped(off) || off == 9'h108) return 32'd0;
        idx = (int'(off) - 16) / 8;
        return (((int'(off) - 16) % 8) == 4) ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_active = 0; m_presc = 0; m_step = 0; m_cnt = 0; m_mtime = '0;
    for (int i = 0; i < N; i++) m_cmp[i] = '1;
    m_state = '0; m_enable = '0; m_intr_line = '0;
  endfunction

  // Advance the model by one clock with the given bus inputs; fills exp_* with post-edge outputs.
  function automatic void model_step(bit r, bit w, logic [8:0] a, logic [31:0] d);
    logic [8:0]   off;
    bit           tick, wr;
    logic [N-1:0] hit, nstate;
    logic [63:0]  nmtime;
    int           idx;
    off  = {a[8:2], 2'b00};
    wr   = r && w;
    tick = m_active && (m_cnt >= m_presc);
    for (int i = 0; i < N; i++) hit[i] = m_active && (m_mtime >= m_cmp[i]);

    exp_rvalid = r;
    exp_err    = r && !is_mapped(off);
    exp_rdata  = (r && !w && is_mapped(off)) ? read_val(off) : 32'd0;
    exp_intr   = m_state & m_enable;

    nmtime = tick ? m_mtime + 64'(m_step) : m_mtime;
    m_cnt  = (!m_active || tick) ? 0 : m_cnt + 1;
    nstate = m_state;
    if (wr && off == 9'h100) nstate = nstate & ~d[N-1:0];
    nstate = nstate | hit;
    if (wr && off == 9'h108) nstate = nstate | d[N-1:0];
    if (wr && off == 9'h008) nmtime = {m_mtime[63:32], d};
    if (wr && off == 9'h00C) nmtime = {d, m_mtime[31:0]};
    if (wr && off == 9'h000) m_active = d[0];
    if (wr && off == 9'h004) begin m_presc = int'(d[11:0]); m_step = int'(d[23:16]); end
    if (wr && off == 9'h104) m_enable = d[N-1:0];
    if (wr && is_mapped(off) && int'(off) >= 16 && int'(off) < 16 + 8 * N) begin
      idx = (int'(off) - 16) / 8;
      if (((int'(off) - 16) % 8) == 4) m_cmp[idx][63:32] = d;
      else                             m_cmp[idx][31:0]  = d;
    end
    m_intr_line = m_state & m_enable;
    m_state = nstate;
    m_mtime = nmtime;
  endfunction

  // One bus cycle: drive, let the edge happen, capture outputs 1 ns later.
  task automatic cycle(input bit r, input bit w, input logic [8:0] a, input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
    model_step(r, w, a, d);
    @(posedge clk);
    #1;
    got_rvalid = rvalid; got_rdata = rdata; got_err = err; got_intr = intr;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [8:0] a);
    cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  function automatic logic [31:0] cfg_word(int presc, int step);
    return {8'd0, 8'(step), 4'd0, 12'(presc)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0]  regs [11];
    logic [31:0] rst_val;
    regs = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010, 9'h014, 9'h018, 9'h01C, 9'h100, 9'h104, 9'h108};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rvalid, err, rdata, intr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rvalid=%b err=%b rdata=%h intr=%b exp all zero", rvalid, err, rdata, intr);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 11; k++) begin
      rst_val = (regs[k] >= 9'h010 && regs[k] <= 9'h01C) ? 32'hFFFF_FFFF : 32'h0;
      rd(regs[k]);
      n_cmp++;
      if (got_rdata !== rst_val || got_err !== 1'b0 || got_rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got rdata=%h err=%b rvalid=%b exp rdata=%h err=0 rvalid=1",
                 regs[k], got_rdata, got_err, got_rvalid, rst_val);
      end
    end
    n_cmp++;
    if (got_intr !== '0) begin
      n_fail++;
      $display("FAIL reset_intr got=%b exp=0", got_intr);
    end
  endtask

  task automatic test_prescaler();
    wr(9'h004, cfg_word(3, 2));
    wr(9'h000, 32'h1);
    for (int k = 0; k < 16; k++) begin
      rd(9'h008);
      n_cmp++;
      if (got_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL prescaler_mtime k=%0d got=%h exp=%h", k, got_rdata, exp_rdata);
      end
    end
    wr(9'h000, 32'h0);
    for (int k = 0; k < 6; k++) begin
      rd(9'h008);
      n_cmp++;
      if (got_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL frozen_mtime k=%0d got=%h exp=%h", k, got_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_compare();
    wr(9'h008, 32'h0);
    wr(9'h00C, 32'h0);
    wr(9'h010, 32'h10);
    wr(9'h014, 32'h0);
    wr(9'h104, 32'h1);
    wr(9'h100, 32'h3);
    wr(9'h004, cfg_word(0, 1));
    wr(9'h000, 32'h1);
    for (int k = 0; k < 24; k++) begin
      rd(9'h100);
      n_cmp++;
      if (got_rdata !== exp_rdata || got_intr !== exp_intr) begin
        n_fail++;
        $display("FAIL compare_state k=%0d got state=%h intr=%b exp state=%h intr=%b",
                 k, got_rdata, got_intr, exp_rdata, exp_intr);
      end
    end
    wr(9'h100, 32'h1);
    rd(9'h100);
    n_cmp++;
    if (got_rdata !== exp_rdata || got_rdata[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_persist got=%h exp=%h", got_rdata, exp_rdata);
    end
    wr(9'h010, 32'hFFFF_FFFF);
    wr(9'h014, 32'hFFFF_FFFF);
    wr(9'h100, 32'h1);
    rd(9'h100);
    n_cmp++;
    if (got_rdata !== exp_rdata || got_rdata[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_clear got=%h exp=%h", got_rdata, exp_rdata);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] seq [6];
    seq = '{9'h008, 9'h00C, 9'h100, 9'h008, 9'h00C, 9'h100};
    wr(9'h000, 32'h0);
    wr(9'h008, 32'hFFFF_FFFE);
    wr(9'h00C, 32'hFFFF_FFFF);
    wr(9'h010, 32'hFFFF_FFFE);
    wr(9'h014, 32'hFFFF_FFFF);
    wr(9'h004, cfg_word(0, 3));
    wr(9'h104, 32'h3);
    wr(9'h100, 32'h3);
    wr(9'h000, 32'h1);
    for (int k = 0; k < 6; k++) begin
      rd(seq[k]);
      n_cmp++;
      if (got_rdata !== exp_rdata || got_intr !== exp_intr) begin
        n_fail++;
        $display("FAIL wrap addr=%h got=%h intr=%b exp=%h intr=%b", seq[k], got_rdata, got_intr, exp_rdata, exp_intr);
      end
    end
    wr(9'h100, 32'h3);
    rd(9'h100);
    n_cmp++;
    if (got_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL wrap_intr_drop got=%h exp=%h", got_rdata, exp_rdata);
    end
  endtask

  task automatic test_tick_collision();
    wr(9'h004, cfg_word(0, 1));
    wr(9'h000, 32'h1);
    wr(9'h008, 32'h55);
    rd(9'h008);
    n_cmp++;
    if (got_rdata !== exp_rdata || got_rdata !== 32'h55) begin
      n_fail++;
      $display("FAIL collide_lo got=%h exp=%h", got_rdata, exp_rdata);
    end
    rd(9'h00C);
    n_cmp++;
    if (got_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL collide_hi got=%h exp=%h", got_rdata, exp_rdata);
    end
  endtask

  task automatic test_err();
    rd(9'h0FC);
    n_cmp++;
    if (got_err !== 1'b1 || got_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL err_unmapped got err=%b rdata=%h exp err=1 rdata=0", got_err, got_rdata);
    end
    rd(9'h108);
    n_cmp++;
    if (got_err !== 1'b0 || got_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL intr_test_read got err=%b rdata=%h exp err=0 rdata=0", got_err, got_rdata);
    end
    wr(9'h028, 32'hDEAD_BEEF);
    n_cmp++;
    if (got_err !== 1'b1 || got_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL err_write got err=%b rdata=%h exp err=1 rdata=0", got_err, got_rdata);
    end
    wr(9'h000, 32'h0);
    wr(9'h104, 32'h0);
    wr(9'h100, 32'h3);
    wr(9'h108, 32'h1);
    rd(9'h100);
    n_cmp++;
    if (got_rdata !== exp_rdata || got_rdata[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL intr_test_state got=%h exp=%h", got_rdata, exp_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      rd(9'h104);
      n_cmp++;
      if (got_intr !== '0) begin
        n_fail++;
        $display("FAIL intr_test_masked k=%0d got=%b exp=0", k, got_intr);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0]  pool [15];
    logic [8:0]  a;
    logic [31:0] d;
    bit          w;
    int          errs;
    pool = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010, 9'h014, 9'h018, 9'h01C,
             9'h100, 9'h104, 9'h108, 9'h028, 9'h0FC, 9'h10C, 9'h1FC};
    errs = 0;
    wr(9'h008, 32'h0);
    wr(9'h00C, 32'h0);
    for (int k = 0; k < 400; k++) begin
      a = pool[$urandom_range(0, 14)] | 9'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if ({a[8:2], 2'b00} == 9'h004) d = d & 32'h0007_0003;
      if ({a[8:2], 2'b00} inside {9'h008, 9'h010, 9'h018} && $urandom_range(0, 7) != 0) d = $urandom_range(0, 300);
      if ({a[8:2], 2'b00} inside {9'h00C, 9'h014, 9'h01C} && $urandom_range(0, 7) != 0) d = 32'h0;
      cycle($urandom_range(0, 4) != 0, w, a, d);
      n_cmp++;
      if (got_rvalid !== exp_rvalid || got_rdata !== exp_rdata || got_err !== exp_err || got_intr !== exp_intr) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random k=%0d addr=%h got v=%b d=%h e=%b i=%b exp v=%b d=%h e=%b i=%b", k, a,
                   got_rvalid, got_rdata, got_err, got_intr, exp_rvalid, exp_rdata, exp_err, exp_intr);
        errs++;
      end
    end
  endtask

  task automatic test_mid_reset();
    wr(9'h104, 32'h3);
    wr(9'h108, 32'h3);
    wr(9'h000, 32'h1);
    rd(9'h008);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, err, rdata, intr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got rvalid=%b err=%b rdata=%h intr=%b exp all zero", rvalid, err, rdata, intr);
    end
    #3;
    rst_n = 1'b1;
    model_reset();
    rd(9'h014);
    n_cmp++;
    if (got_rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mid_reset_cmp got=%h exp=ffffffff", got_rdata);
    end
    rd(9'h000);
    n_cmp++;
    if (got_rdata !== 32'h0 || got_intr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl got=%h intr=%b exp 0", got_rdata, got_intr);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prescaler();
    test_compare();
    test_wrap();
    test_tick_collision();
    test_err();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
